// File: rtl/mem_stage_hs.sv
// mem_stage_hs: EX -> MEM -> WB stage with a valid/ready data-memory handshake,
// access timeout and sticky halt. Define MEMSTG_STALL_CNT_EN to add the stall_cnt output.
module mem_stage_hs #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int TGT_W    = 3,
  parameter int OP_W     = 3,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble_in,
  input  logic [OP_W-1:0]   opcode_in,
  input  logic [TGT_W-1:0]  tgt_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] sdata_in,
  input  logic              halt_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [TGT_W-1:0]  tgt_out,
  output logic [OP_W-1:0]   opcode_out,
  output logic [DATA_W-1:0] result_out,
  output logic              bubble_out,
  output logic              halt_out,
`ifdef MEMSTG_STALL_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
`endif
  output logic              err_out
);

  localparam logic [2:0] OP_SW = 3'b100;
  localparam logic [2:0] OP_LW = 3'b101;
  localparam int WC_W = $clog2(MAX_WAIT + 1);

  if (MAX_WAIT < 1 || CNT_W < 1) begin : g_param_check
    $error("mem_stage_hs: MAX_WAIT and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_HALTED = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [WC_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [TGT_W-1:0]  tgt_reg;
  logic [OP_W-1:0]   opcode_reg;
  logic [DATA_W-1:0] result_reg;
  logic              bubble_reg, halt_reg, err_reg;

  logic              is_sw, is_lw, mem_op, halt_take, timeout;
  logic              req_c, stall_c, load_c, bubble_c, halt_set, err_set;
  logic [DATA_W-1:0] result_d;

  assign is_sw     = (opcode_in[2:0] == OP_SW);
  assign is_lw     = (opcode_in[2:0] == OP_LW);
  // A halt occupying the slot must never reach memory, whatever its opcode.
  assign mem_op    = !bubble_in && (is_sw || is_lw) && !halt_in && !halt_reg;
  assign halt_take = halt_in && !bubble_in;
  assign timeout   = (wait_cnt_reg == WC_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (halt_take) begin
          state_next = S_HALTED;
        end else if (mem_op && !mem_ready) begin
          state_next    = S_BUSY;
          wait_cnt_next = WC_W'(1);
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_next    = S_IDLE;
          wait_cnt_next = '0;
        end else if (timeout) begin
          state_next    = S_HALTED;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + WC_W'(1);
        end
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_c    = 1'b0;
    stall_c  = 1'b0;
    load_c   = 1'b0;
    bubble_c = 1'b1;
    halt_set = 1'b0;
    err_set  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        req_c   = mem_op;
        stall_c = mem_op && !mem_ready;
        if (halt_take) begin
          halt_set = 1'b1;
        end else if (!mem_op) begin
          load_c   = 1'b1;
          bubble_c = bubble_in;
        end else if (mem_ready) begin
          load_c   = 1'b1;
          bubble_c = 1'b0;
        end
      end
      S_BUSY: begin
        req_c   = 1'b1;
        stall_c = !mem_ready;
        if (mem_ready) begin
          load_c   = 1'b1;
          bubble_c = 1'b0;
        end else if (timeout) begin
          halt_set = 1'b1;
          err_set  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset must kill an in-flight request combinationally, not at the next edge.
  assign mem_req   = rst_n && req_c;
  assign stall_out = rst_n && stall_c;
  assign mem_we    = mem_req && is_sw;
  assign mem_addr  = result_in[ADDR_W-1:0];
  assign mem_wdata = sdata_in;
  assign result_d  = (req_c && is_lw) ? mem_rdata : result_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_reg    <= '0;
      opcode_reg <= '0;
      result_reg <= '0;
      bubble_reg <= 1'b1;
      halt_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      if (load_c) begin
        tgt_reg    <= tgt_in;
        opcode_reg <= opcode_in;
        result_reg <= result_d;
      end
      bubble_reg <= bubble_c;
      if (halt_set) halt_reg <= 1'b1;
      if (err_set)  err_reg  <= 1'b1;
    end
  end

  assign tgt_out    = tgt_reg;
  assign opcode_out = opcode_reg;
  assign result_out = result_reg;
  assign bubble_out = bubble_reg;
  assign halt_out   = halt_reg;
  assign err_out    = err_reg;

`ifdef MEMSTG_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall_out && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed stimulus for mem_stage_hs, checked every cycle against a
// transaction-level model plus hand-computed literal expectations.
module tb_mem_stage_hs;

  localparam int MAX_WAIT = 15;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;

  logic        clk;
  logic        rst_n;
  logic        bubble_in;
  logic [2:0]  opcode_in;
  logic [2:0]  tgt_in;
  logic [15:0] result_in;
  logic [15:0] sdata_in;
  logic        halt_in;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [2:0]  tgt_out;
  logic [2:0]  opcode_out;
  logic [15:0] result_out;
  logic        bubble_out;
  logic        halt_out;
  logic        err_out;
`ifdef MEMSTG_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  mem_stage_hs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bubble_in  (bubble_in),
    .opcode_in  (opcode_in),
    .tgt_in     (tgt_in),
    .result_in  (result_in),
    .sdata_in   (sdata_in),
    .halt_in    (halt_in),
    .stall_out  (stall_out),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .tgt_out    (tgt_out),
    .opcode_out (opcode_out),
    .result_out (result_out),
    .bubble_out (bubble_out),
    .halt_out   (halt_out),
`ifdef MEMSTG_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .err_out    (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Model: an access in flight counts how many cycles it has already stalled;
  // after MAX_WAIT further refusals the stage gives up and halts for good.
  int          m_wait;
  logic        m_halted, m_err, m_bub;
  logic [2:0]  m_tgt, m_op;
  logic [15:0] m_res, m_scnt;
  logic        m_memop, exp_req, exp_stall;

  assign m_memop   = !bubble_in && (opcode_in == OP_SW || opcode_in == OP_LW) && !halt_in && !m_halted;
  assign exp_req   = rst_n && !m_halted && (m_wait != 0 || m_memop);
  assign exp_stall = exp_req && !mem_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 0; m_halted <= 1'b0; m_err <= 1'b0; m_bub <= 1'b1;
      m_tgt <= '0; m_op <= '0; m_res <= '0; m_scnt <= '0;
    end else begin
      if (exp_stall && m_scnt != 16'hFFFF) m_scnt <= m_scnt + 16'd1;
      if (m_halted) begin
        m_bub <= 1'b1;
      end else if (exp_req) begin
        if (mem_ready) begin
          m_tgt <= tgt_in; m_op <= opcode_in; m_bub <= 1'b0; m_wait <= 0;
          m_res <= (opcode_in == OP_LW) ? mem_rdata : result_in;
        end else if (m_wait == MAX_WAIT) begin
          m_halted <= 1'b1; m_err <= 1'b1; m_bub <= 1'b1; m_wait <= 0;
        end else begin
          m_wait <= m_wait + 1; m_bub <= 1'b1;
        end
      end else if (halt_in && !bubble_in) begin
        m_halted <= 1'b1; m_bub <= 1'b1;
      end else begin
        m_tgt <= tgt_in; m_op <= opcode_in; m_res <= result_in; m_bub <= bubble_in;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_mem_req", 32'(mem_req), 32'(exp_req));
    chk("cyc_stall", 32'(stall_out), 32'(exp_stall));
    if (exp_req) begin
      chk("cyc_mem_we", 32'(mem_we), 32'(opcode_in == OP_SW));
      chk("cyc_mem_addr", 32'(mem_addr), 32'(result_in));
      if (opcode_in == OP_SW) chk("cyc_mem_wdata", 32'(mem_wdata), 32'(sdata_in));
    end
    chk("cyc_bubble", 32'(bubble_out), 32'(m_bub));
    chk("cyc_halt", 32'(halt_out), 32'(m_halted));
    chk("cyc_err", 32'(err_out), 32'(m_err));
    if (!m_bub) begin
      chk("cyc_tgt", 32'(tgt_out), 32'(m_tgt));
      chk("cyc_opcode", 32'(opcode_out), 32'(m_op));
      chk("cyc_result", 32'(result_out), 32'(m_res));
    end
`ifdef MEMSTG_STALL_CNT_EN
    chk("cyc_stall_cnt", 32'(stall_cnt), 32'(m_scnt));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bub, input logic [2:0] op, input logic [2:0] tgt,
                       input logic [15:0] res, input logic [15:0] sd, input logic hlt);
    bubble_in = bub; opcode_in = op; tgt_in = tgt;
    result_in = res; sdata_in = sd; halt_in = hlt;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    drive(1'b1, OP_ADD, 3'd0, 16'h0000, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bubble", 32'(bubble_out), 32'd1);
    chk("rst_halt", 32'(halt_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_tgt", 32'(tgt_out), 32'd0);
    chk("rst_result", 32'(result_out), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU op passes straight through
    drive(1'b0, OP_ADD, 3'd3, 16'h1234, 16'h0000, 1'b0);
    #1 chk("add_req", 32'(mem_req), 32'd0);
    tick();
    chk("add_tgt", 32'(tgt_out), 32'd3);
    chk("add_result", 32'(result_out), 32'h1234);
    chk("add_bubble", 32'(bubble_out), 32'd0);

    // Load completing in the issue cycle
    drive(1'b0, OP_LW, 3'd5, 16'h0040, 16'h0000, 1'b0);
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    chk("lw_req", 32'(mem_req), 32'd1);
    chk("lw_we", 32'(mem_we), 32'd0);
    chk("lw_addr", 32'(mem_addr), 32'h0040);
    chk("lw_stall", 32'(stall_out), 32'd0);
    tick();
    chk("lw_result", 32'(result_out), 32'hBEEF);
    chk("lw_bubble", 32'(bubble_out), 32'd0);
    chk("lw_tgt", 32'(tgt_out), 32'd5);

    // A store in an empty slot stays off the bus
    drive(1'b1, OP_SW, 3'd0, 16'h0010, 16'h00AA, 1'b0);
    mem_ready = 1'b0;
    #1 chk("swb_req", 32'(mem_req), 32'd0);
    tick();

    // Store with three refused cycles
    drive(1'b0, OP_SW, 3'd2, 16'h0010, 16'h00AA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sw_stall", 32'(stall_out), 32'd1);
      chk("sw_we", 32'(mem_we), 32'd1);
      chk("sw_wdata", 32'(mem_wdata), 32'h00AA);
      tick();
      chk("sw_bubble_wait", 32'(bubble_out), 32'd1);
    end
    mem_ready = 1'b1;
    #1 chk("sw_stall_end", 32'(stall_out), 32'd0);
    tick();
    chk("sw_bubble_done", 32'(bubble_out), 32'd0);
    chk("sw_result", 32'(result_out), 32'h0010);
`ifdef MEMSTG_STALL_CNT_EN
    chk("sw_stall_cnt", 32'(stall_cnt), 32'd3);
`endif
    drive(1'b1, OP_ADD, 3'd0, 16'h0000, 16'h0000, 1'b0);
    mem_ready = 1'b0;
    tick();

    // Reset in the middle of a refused load
    drive(1'b0, OP_LW, 3'd1, 16'h0020, 16'h0000, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rb_req", 32'(mem_req), 32'd0);
    chk("rb_stall", 32'(stall_out), 32'd0);
    chk("rb_bubble", 32'(bubble_out), 32'd1);
    chk("rb_result", 32'(result_out), 32'd0);
    chk("rb_tgt", 32'(tgt_out), 32'd0);
`ifdef MEMSTG_STALL_CNT_EN
    chk("rb_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    bubble_in = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Load never acknowledged: 1 issue cycle + MAX_WAIT busy cycles, then abort
    drive(1'b0, OP_LW, 3'd6, 16'h0080, 16'h0000, 1'b0);
    for (int i = 0; i < MAX_WAIT; i++) tick();
    chk("to_err_pre", 32'(err_out), 32'd0);
    chk("to_stall_pre", 32'(stall_out), 32'd1);
    tick();
    chk("to_err", 32'(err_out), 32'd1);
    chk("to_halt", 32'(halt_out), 32'd1);
    chk("to_req", 32'(mem_req), 32'd0);
    chk("to_bubble", 32'(bubble_out), 32'd1);
    repeat (3) tick();
    chk("to_err_hold", 32'(err_out), 32'd1);
    rst_n = 1'b0;
    bubble_in = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Halt instruction (with a load opcode) then a store that must never issue
    drive(1'b0, OP_LW, 3'd0, 16'h0050, 16'h0000, 1'b1);
    mem_ready = 1'b1;
    #1 chk("halt_req", 32'(mem_req), 32'd0);
    tick();
    chk("halt_out", 32'(halt_out), 32'd1);
    drive(1'b0, OP_SW, 3'd2, 16'h0030, 16'h0055, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hs_req", 32'(mem_req), 32'd0);
      chk("hs_bubble", 32'(bubble_out), 32'd1);
      tick();
    end

    rst_n = 1'b0;
    #1;
    chk("fin_halt", 32'(halt_out), 32'd0);
    chk("fin_req", 32'(mem_req), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
